// File: rtl/color_xform_pipe.sv
// color_xform_pipe: 3-stage valid/ready colour transform (pass, invert, grayscale, protan correction)
// with a global stall, saturating fixed-point arithmetic and an output pixel counter.
module color_xform_pipe #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [PIX_W-1:0] r_in,
    input  logic [PIX_W-1:0] g_in,
    input  logic [PIX_W-1:0] b_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] r_out,
    output logic [PIX_W-1:0] g_out,
    output logic [PIX_W-1:0] b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] px_count
);
    localparam int W = PIX_W + FRAC_W + 2;
    localparam int K = FRAC_W - 6;
    localparam logic [PIX_W-1:0] MAXP = {PIX_W{1'b1}};
    localparam logic [W-1:0] C_YR = W'(13 * (1 << K));
    localparam logic [W-1:0] C_YG = W'(46 * (1 << K));
    localparam logic [W-1:0] C_YB = W'(4 * (1 << K));
    localparam logic [W-1:0] C_GR = W'(23 * (1 << K));
    localparam logic [W-1:0] C_GG = W'(47 * (1 << K));
    localparam logic [W-1:0] C_BR = W'(29 * (1 << K));
    localparam logic [W-1:0] C_BG = W'(27 * (1 << K));
    localparam logic [W-1:0] C_BB = W'(64 * (1 << K));

    logic             v1, v2;
    logic [1:0]       m1, m2;
    logic [PIX_W-1:0] r1, g1, b1;
    logic [W-1:0]     s_r, s_g, s_b;
    logic [W-1:0]     er, eg, eb, y, gc, bc, p_r, p_g, p_b;
    logic             advance;

    function automatic logic [PIX_W-1:0] sat(input logic [W-1:0] s);
        logic [W-1:0] q;
        q = s >> FRAC_W;
        return (|q[W-1:PIX_W]) ? MAXP : q[PIX_W-1:0];
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Pass/invert results are stored unscaled; only the weighted modes go through shift+clamp in S3.
    always_comb begin
        er  = W'(r1);
        eg  = W'(g1);
        eb  = W'(b1);
        y   = C_YR * er + C_YG * eg + C_YB * eb;
        gc  = C_GR * er + C_GG * eg;
        bc  = C_BR * er + C_BG * eg + C_BB * eb;
        p_r = m1 == 2'd0 ? er : m1 == 2'd1 ? W'(MAXP) - er : m1 == 2'd2 ? y : er << FRAC_W;
        p_g = m1 == 2'd0 ? eg : m1 == 2'd1 ? W'(MAXP) - eg : m1 == 2'd2 ? y : gc;
        p_b = m1 == 2'd0 ? eb : m1 == 2'd1 ? W'(MAXP) - eb : m1 == 2'd2 ? y : bc;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            m1        <= '0;
            m2        <= '0;
            r1        <= '0;
            g1        <= '0;
            b1        <= '0;
            s_r       <= '0;
            s_g       <= '0;
            s_b       <= '0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            m1        <= mode;
            r1        <= r_in;
            g1        <= g_in;
            b1        <= b_in;
            v2        <= v1;
            m2        <= m1;
            s_r       <= p_r;
            s_g       <= p_g;
            s_b       <= p_b;
            out_valid <= v2;
            r_out     <= m2[1] ? sat(s_r) : s_r[PIX_W-1:0];
            g_out     <= m2[1] ? sat(s_g) : s_g[PIX_W-1:0];
            b_out     <= m2[1] ? sat(s_b) : s_b[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            px_count <= '0;
        else if (out_valid && out_ready)
            px_count <= px_count + 1'b1;
    end
endmodule

// File: doc/color_xform_pipe.md
COLOR_XFORM_PIPE -- requirements
Module: color_xform_pipe

Interface
REQ-001 Parameter PIX_W, default 8, SHALL set the bit width of each colour channel.
REQ-002 Parameter FRAC_W, default 6, SHALL set the coefficient fractional bits; legal values are FRAC_W >= 6.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the pixel counter.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 n_rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 r_in, g_in, b_in  in  PIX_W each  SHALL carry the input pixel channels.
REQ-007 mode  in  2  SHALL select the transform: 00 pass, 01 invert, 10 grayscale, 11 protan correction.
REQ-008 in_valid  in  1 / in_ready  out  1  SHALL form the input handshake.
REQ-009 r_out, g_out, b_out  out  PIX_W each  SHALL carry the result pixel channels.
REQ-010 out_valid  out  1 / out_ready  in  1  SHALL form the output handshake.
REQ-011 px_count  out  CNT_W  SHALL hold the number of output pixels accepted since reset.

Function
REQ-012 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-013 The pipeline SHALL have 3 register stages: S1 captures channels+mode, S2 forms the products and sums, S3 applies shift/clamp and drives the outputs.
REQ-014 Latency SHALL be exactly 3 cycles from input transfer to out_valid when there is no stall.
REQ-015 Each stage SHALL carry a valid bit and its own copy of mode, so mixed modes in flight are each transformed by their own mode.
REQ-016 The pipeline SHALL use a global stall: advance = !S3_valid || out_ready; in_ready = advance; no stage updates while advance is 0.
REQ-017 Under stall, outputs SHALL hold stable and no pixel SHALL be dropped, duplicated or reordered.
REQ-018 Bubbles SHALL propagate: an empty stage loads valid=0 when advance is 1.
REQ-019 Mode 00 SHALL pass r, g, b unchanged.
REQ-020 Mode 01 SHALL output (2^PIX_W-1) minus each channel.
REQ-021 Mode 10 SHALL compute Y = (13r + 46g + 4b) >> 6 (FRAC_W=6 form) and drive Y on all three channels.
REQ-022 Mode 11 SHALL compute R = r, G = (23r + 47g) >> 6, B = (29r + 27g + 64b) >> 6 (FRAC_W=6 form).
REQ-023 Coefficients SHALL be the FRAC_W=6 integers shifted left by FRAC_W-6, with the final shift equal to FRAC_W.
REQ-024 Products and sums SHALL be held at full width, PIX_W+FRAC_W+2 bits, with no intermediate truncation.
REQ-025 Results greater than 2^PIX_W-1 SHALL saturate to 2^PIX_W-1; results are never negative.
REQ-026 px_count SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-027 in_valid SHALL be sampled only when in_ready is 1; inputs presented while stalled SHALL be ignored until accepted.

Reset
REQ-028 Asserting n_rst low SHALL, without waiting for a clock edge, clear all stage valid bits, out_valid, px_count, r_out, g_out and b_out to 0.
REQ-029 in_ready SHALL read 1 while in reset and on the first cycle after reset release.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight pixels; after release, no stale pixel SHALL appear at the output.

Verification
REQ-031 Grayscale: mode=10, (100,200,50), out_ready=1 -> (167,167,167), with out_valid high exactly 3 cycles after the input transfer.
REQ-032 Invert and pass: mode=01 (0,255,10) -> (255,0,245); the next cycle mode=00 (1,2,3) -> (1,2,3) on consecutive cycles.
REQ-033 Correction with saturation: mode=11 (200,100,250) -> (200,145,255).
REQ-034 Backpressure: stream 4 pixels with out_ready held low for 5 cycles -> in_ready low once S3 is full, outputs stable, then all 4 pixels emerge in order and px_count=4.
REQ-035 Reset mid-stream: 2 pixels in flight, pulse n_rst low between clock edges -> out_valid=0 and px_count=0 immediately, and no output after release until new input.
REQ-036 Counter wrap: CNT_W=4, 17 output transfers -> px_count=1.
